// File: rtl/ascon_perm_iter_pkg.sv
// ascon_pkg -- shared definitions for the iterative Ascon permutation engine.
//
// Contents:
//   STATE_W / WORD_W / NUM_WORDS : 320-bit state made of five 64-bit words
//   PA_ROUNDS                    : round count of the pa permutation
//   state_t                      : engine FSM state encoding (IDLE, RUN, DONE)
//   rc(ir)                       : 64-bit round constant for global round index ir
//   ror(w, n)                    : 64-bit right rotation
//   get_word / pack_words        : state-word slice helpers
//                                  (x0 = [63:0] ... x4 = [319:256])
package ascon_pkg;

    localparam int STATE_W   = 320;
    localparam int WORD_W    = 64;
    localparam int NUM_WORDS = 5;
    localparam int PA_ROUNDS = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Round constant: upper nibble counts down from f while the lower
    // nibble counts up, so pa starts at 0xf0 and every permutation ends at 0x4b.
    function automatic logic [WORD_W-1:0] rc(input logic [3:0] ir);
        return {56'h0, 4'hf - ir, ir};
    endfunction

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] w, input int unsigned n);
        return (w >> n) | (w << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] get_word(input logic [STATE_W-1:0] s,
                                                   input int unsigned idx);
        return s[idx*WORD_W +: WORD_W];
    endfunction

    function automatic logic [STATE_W-1:0] pack_words(input logic [WORD_W-1:0] w0,
                                                      input logic [WORD_W-1:0] w1,
                                                      input logic [WORD_W-1:0] w2,
                                                      input logic [WORD_W-1:0] w3,
                                                      input logic [WORD_W-1:0] w4);
        return {w4, w3, w2, w1, w0};
    endfunction

endpackage

// File: rtl/ascon_perm_iter_if.sv
// ascon_perm_iter_if -- load/result bus between the mode controller and the
// permutation engine.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_valid/in_state/in_mode are driven by the mode controller
// and consumed by the engine on in_valid & in_ready; out_valid/out_state are
// driven by the engine and held stable until out_valid & out_ready.
//
// Signals:
//   in_valid   load request            in_ready   engine can accept a load
//   in_state   320-bit state to load   in_mode    1 = pa (12 rounds), 0 = pb
//   out_valid  result available        out_ready  consumer takes result
//   out_state  permuted state
//
// Modports: master = mode controller side, slave = permutation engine.
interface ascon_perm_iter_if;
    import ascon_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_state;
    logic               in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;

    modport master (
        output in_valid,
        output in_state,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );

endinterface

// File: rtl/ascon_perm_iter_round.sv
// ascon_round -- one purely combinational Ascon round.
//
// Ports:
//   state_in   320-bit input state (x0 = [63:0] ... x4 = [319:256])
//   ir         4-bit global round index selecting the round constant
//   state_out  320-bit state after constant addition, S-box and linear layer
module ascon_round
    import ascon_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    input  logic [3:0]         ir,
    output logic [STATE_W-1:0] state_out
);

    logic [WORD_W-1:0] a0, a1, a2, a3, a4;
    logic [WORD_W-1:0] t0, t1, t2, t3, t4;
    logic [WORD_W-1:0] l0, l1, l2, l3, l4;

    always_comb begin
        // Constant addition on x2.
        a0 = get_word(state_in, 0);
        a1 = get_word(state_in, 1);
        a2 = get_word(state_in, 2) ^ rc(ir);
        a3 = get_word(state_in, 3);
        a4 = get_word(state_in, 4);

        // Bitsliced 5-bit S-box: input mixing.
        a0 = a0 ^ a4;
        a4 = a4 ^ a3;
        a2 = a2 ^ a1;

        // Chi-like core; every t_i is taken from the mixed words before any
        // of them is updated.
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;

        // Output mixing.
        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;

        // Linear diffusion layer, one rotation pair per word.
        l0 = a0 ^ ror(a0, 19) ^ ror(a0, 28);
        l1 = a1 ^ ror(a1, 61) ^ ror(a1, 39);
        l2 = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
        l3 = a3 ^ ror(a3, 10) ^ ror(a3, 17);
        l4 = a4 ^ ror(a4, 7)  ^ ror(a4, 41);

        state_out = pack_words(l0, l1, l2, l3, l4);
    end

endmodule

// File: rtl/ascon_perm_iter.sv
// ascon_perm_iter -- iterative Ascon permutation engine (pa / pb).
//
// A state loaded in IDLE is run through nr rounds (12 for pa, ROUNDS_B for
// pb), UNROLL rounds per clock, then presented on out_state until the
// consumer takes it.
//
// Parameters:
//   UNROLL    rounds per clock, 1 or 2
//   ROUNDS_B  pb round count, 6 or 8
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        ascon_perm_iter_if.slave (load and result handshakes)
//   busy       high while rounds are being computed (RUN)
//   dbg_state  current FSM state
//   dbg_rc     low byte of the round constant applied first in this cycle
//   abort      (only with ASCON_PERM_ABORT_EN) drops a run or a pending
//              result and returns to IDLE at the next edge
//
// Build option: define ASCON_PERM_ABORT_EN to add the abort input.
module ascon_perm_iter
    import ascon_pkg::*;
#(
    parameter int UNROLL   = 1,
    parameter int ROUNDS_B = 6
) (
    input  logic              clk,
    input  logic              rst,
    ascon_perm_iter_if.slave  bus,
    output logic              busy,
    output state_t            dbg_state,
    output logic [7:0]        dbg_rc
`ifdef ASCON_PERM_ABORT_EN
    ,
    input  logic              abort
`endif
);

    // Both legal unroll factors divide 12, 6 and 8, so this check is also
    // the divisibility check.
    if (!((UNROLL == 1 || UNROLL == 2) && (ROUNDS_B == 6 || ROUNDS_B == 8))) begin : g_bad_param
        $fatal(1, "ascon_perm_iter: illegal UNROLL=%0d / ROUNDS_B=%0d", UNROLL, ROUNDS_B);
    end

    localparam logic [3:0] NR_A = 4'(PA_ROUNDS);
    localparam logic [3:0] NR_B = 4'(ROUNDS_B);
    localparam logic [3:0] STEP = 4'(UNROLL);

    state_t             st_q, st_d;
    logic [STATE_W-1:0] sv_q, sv_d;   // working state, doubles as the result
    logic [3:0]         r_q, r_d;     // rounds completed so far
    logic [3:0]         nr_q, nr_d;   // rounds of the selected permutation
    logic [3:0]         ir_base;      // global index of the first round this cycle

    // Round chain: chain[0] is the register, chain[UNROLL] the next value.
    logic [STATE_W-1:0] chain [UNROLL+1];

    // pb uses the last nr indices of pa, hence the 12 - nr offset.
    assign ir_base  = NR_A - nr_q + r_q;
    assign chain[0] = sv_q;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        ascon_round u_round (
            .state_in  (chain[u]),
            .ir        (ir_base + 4'(u)),
            .state_out (chain[u+1])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sv_q <= '0;
            r_q  <= '0;
            nr_q <= '0;
        end else begin
            sv_q <= sv_d;
            r_q  <= r_d;
            nr_q <= nr_d;
        end
    end

    // Next state and datapath updates.
    always_comb begin
        st_d = st_q;
        sv_d = sv_q;
        r_d  = r_q;
        nr_d = nr_q;

        case (st_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sv_d = bus.in_state;
                    nr_d = bus.in_mode ? NR_A : NR_B;
                    r_d  = '0;
                    st_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sv_d = chain[UNROLL];
                r_d  = r_q + STEP;
                if (r_q + STEP == nr_q) begin
                    st_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // No reload on the handshake edge: a new load needs IDLE.
                if (bus.out_ready) begin
                    st_d = ST_IDLE;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase

`ifdef ASCON_PERM_ABORT_EN
        // Abort overrides everything, including a coincident out_ready.
        if (abort && st_q != ST_IDLE) begin
            st_d = ST_IDLE;
        end
`endif
    end

    // Outputs are decoded from the registered state, so in_ready is already
    // high while rst is asserted.
    assign bus.in_ready  = (st_q == ST_IDLE);
    assign bus.out_valid = (st_q == ST_DONE);
    assign bus.out_state = sv_q;
    assign busy          = (st_q == ST_RUN);
    assign dbg_state     = st_q;
    assign dbg_rc        = {4'hf - ir_base, ir_base};

endmodule

// File: tb/tb_ascon_perm_iter.sv
// tb_ascon_perm_iter -- self-checking bench for ascon_perm_iter.
//
// Three engines run side by side on one clock and reset:
//   dut 0: UNROLL=1, ROUNDS_B=6
//   dut 1: UNROLL=2, ROUNDS_B=6
//   dut 2: UNROLL=1, ROUNDS_B=8
// Expected results come from a word/bit-slice reference model built on the
// Ascon S-box lookup table and a round-constant table.
// With ASCON_PERM_ABORT_EN defined the abort sequences are exercised too.
module tb_ascon_perm_iter;
    import ascon_pkg::*;

    localparam int ND = 3;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    localparam logic [7:0] RC_TAB [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- per-engine stimulus / observation ----------------
    logic               iv   [ND];
    logic               imd  [ND];
    logic               ordy [ND];
    logic               ab   [ND];
    logic [STATE_W-1:0] ist  [ND];
    logic               ov   [ND];
    logic               ir   [ND];
    logic               bz   [ND];
    logic [STATE_W-1:0] ost  [ND];
    logic [7:0]         drc  [ND];
    state_t             dst  [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        ascon_perm_iter_if bus ();

        assign bus.in_valid  = iv[g];
        assign bus.in_state  = ist[g];
        assign bus.in_mode   = imd[g];
        assign bus.out_ready = ordy[g];
        assign ov[g]         = bus.out_valid;
        assign ir[g]         = bus.in_ready;
        assign ost[g]        = bus.out_state;

        ascon_perm_iter #(
            .UNROLL   ((g == 1) ? 2 : 1),
            .ROUNDS_B ((g == 2) ? 8 : 6)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus),
            .busy      (bz[g]),
            .dbg_state (dst[g]),
            .dbg_rc    (drc[g])
`ifdef ASCON_PERM_ABORT_EN
            ,
            .abort     (ab[g])
`endif
        );
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [STATE_W-1:0] act,
                         input logic [STATE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] w, input int n);
        return (w >> n) | (w << (64 - n));
    endfunction

    function automatic logic [STATE_W-1:0] model_perm(input logic [STATE_W-1:0] st,
                                                      input int nrounds);
        logic [63:0] x [5];
        logic [4:0]  v;
        logic [4:0]  s;
        for (int i = 0; i < 5; i++) x[i] = st[i*64 +: 64];
        for (int r = 0; r < nrounds; r++) begin
            x[2][7:0] = x[2][7:0] ^ RC_TAB[12 - nrounds + r];
            for (int j = 0; j < 64; j++) begin
                v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                s = SBOX[v];
                {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]} = s;
            end
            x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
            x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
            x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
            x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
            x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        end
        return {x[4], x[3], x[2], x[1], x[0]};
    endfunction

    function automatic int nr_of(input int d, input logic mode);
        return mode ? 12 : ((d == 2) ? 8 : 6);
    endfunction

    function automatic int unroll_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic logic [STATE_W-1:0] rand_state();
        logic [STATE_W-1:0] s;
        for (int i = 0; i < 10; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    // Loads st into engine d, waits (bounded) for out_valid and returns the
    // result, the number of edges from acceptance to out_valid and the first
    // and last round constants seen. With noise set, in_valid/out_ready are
    // waved at the engine while it runs. With rel set the result is taken.
    task automatic do_perm(input int d, input logic [STATE_W-1:0] st, input logic mode,
                           input bit noise, input bit rel,
                           output logic [STATE_W-1:0] res, output int lat,
                           output logic [7:0] rc_first, output logic [7:0] rc_last);
        int w = 0;
        while (ir[d] !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        iv[d] = 1'b1; ist[d] = st; imd[d] = mode;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        rc_first = drc[d];
        rc_last  = drc[d];
        lat = 0;
        while (ov[d] !== 1'b1 && lat < 40) begin
            if (noise) begin
                iv[d] = 1'b1; ist[d] = rand_state(); imd[d] = ~mode; ordy[d] = 1'b1;
            end
            if (bz[d] === 1'b1) rc_last = drc[d];
            @(posedge clk); #1; lat++;
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b0;
        res = ost[d];
        if (rel) begin
            ordy[d] = 1'b1;
            @(posedge clk); #1;
            ordy[d] = 1'b0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int                 dut;
        logic [STATE_W-1:0] st;
        logic               mode;
        bit                 noise;
        int                 lat;
        logic [7:0]         rc0;
        logic [7:0]         rcl;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [STATE_W-1:0] res, exp_s, st;
        int                 lat;
        logic [7:0]         rc0, rcl;
        logic               mode;
        bit                 seen;

        for (int d = 0; d < ND; d++) begin
            iv[d] = 1'b0; imd[d] = 1'b0; ordy[d] = 1'b0; ab[d] = 1'b0; ist[d] = '0;
        end

        vecs[0] = '{0, '0,                          1'b1, 1'b0, 12, 8'hf0, 8'h4b};
        vecs[1] = '{0, '0,                          1'b0, 1'b0, 6,  8'h96, 8'h4b};
        vecs[2] = '{2, '0,                          1'b0, 1'b0, 8,  8'hb4, 8'h4b};
        vecs[3] = '{1, '0,                          1'b1, 1'b0, 6,  8'hf0, 8'h00};
        vecs[4] = '{1, {STATE_W{1'b1}},             1'b0, 1'b0, 3,  8'h96, 8'h00};
        vecs[5] = '{2, {5{64'h0123456789abcdef}},   1'b1, 1'b1, 12, 8'hf0, 8'h4b};
        vecs[6] = '{0, rand_state(),                1'b0, 1'b1, 6,  8'h96, 8'h4b};

        // ---- reset state, sampled while rst is still high ----
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst_out_valid%0d", d), 320'(ov[d]), 320'(1'b0));
            check($sformatf("rst_out_state%0d", d), ost[d], '0);
            check($sformatf("rst_busy%0d", d), 320'(bz[d]), 320'(1'b0));
            check($sformatf("rst_in_ready%0d", d), 320'(ir[d]), 320'(1'b1));
            check($sformatf("rst_fsm%0d", d), 320'(dst[d]), 320'(ST_IDLE));
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < 7; i++) begin
            do_perm(vecs[i].dut, vecs[i].st, vecs[i].mode, vecs[i].noise, 1'b1,
                    res, lat, rc0, rcl);
            exp_s = model_perm(vecs[i].st, nr_of(vecs[i].dut, vecs[i].mode));
            check($sformatf("vec%0d_state", i), res, exp_s);
            check($sformatf("vec%0d_latency", i), 320'(lat), 320'(vecs[i].lat));
            check($sformatf("vec%0d_rc_first", i), 320'(rc0), 320'(vecs[i].rc0));
            if (unroll_of(vecs[i].dut) == 1)
                check($sformatf("vec%0d_rc_last", i), 320'(rcl), 320'(vecs[i].rcl));
        end

        // ---- random states on the 2-round-per-clock engine, both modes ----
        for (int i = 0; i < 1000; i++) begin
            st   = rand_state();
            mode = 1'($urandom_range(0, 1));
            do_perm(1, st, mode, 1'b0, 1'b1, res, lat, rc0, rcl);
            check($sformatf("rnd%0d_state", i), res, model_perm(st, nr_of(1, mode)));
            check($sformatf("rnd%0d_latency", i), 320'(lat), 320'(mode ? 6 : 3));
        end

        // ---- result held in DONE while out_ready stays low ----
        st = rand_state();
        exp_s = model_perm(st, 12);
        do_perm(0, st, 1'b1, 1'b0, 1'b0, res, lat, rc0, rcl);
        check("hold_first_state", res, exp_s);
        for (int k = 0; k < 5; k++) begin
            iv[0] = 1'($urandom_range(0, 1)); ist[0] = rand_state(); imd[0] = 1'b0;
            @(posedge clk); #1;
            check($sformatf("hold%0d_out_valid", k), 320'(ov[0]), 320'(1'b1));
            check($sformatf("hold%0d_out_state", k), ost[0], exp_s);
            check($sformatf("hold%0d_in_ready", k), 320'(ir[0]), 320'(1'b0));
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check("release_fsm", 320'(dst[0]), 320'(ST_IDLE));
        check("release_out_valid", 320'(ov[0]), 320'(1'b0));
        check("release_in_ready", 320'(ir[0]), 320'(1'b1));
        @(posedge clk); #1;
        check("release_no_reload", 320'(bz[0]), 320'(1'b0));

        // ---- asynchronous reset in the middle of a pa run ----
        iv[0] = 1'b1; ist[0] = rand_state(); imd[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 320'(ov[0]), 320'(1'b0));
        check("arst_busy", 320'(bz[0]), 320'(1'b0));
        check("arst_in_ready", 320'(ir[0]), 320'(1'b1));
        check("arst_fsm", 320'(dst[0]), 320'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        st = rand_state();
        do_perm(0, st, 1'b1, 1'b0, 1'b1, res, lat, rc0, rcl);
        check("arst_reload_state", res, model_perm(st, 12));
        check("arst_reload_latency", 320'(lat), 320'(12));

`ifdef ASCON_PERM_ABORT_EN
        // ---- abort held with the load edge is ignored in IDLE ----
        iv[0] = 1'b1; ist[0] = rand_state(); imd[0] = 1'b1; ab[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0; ab[0] = 1'b0;
        check("abort_idle_loads", 320'(bz[0]), 320'(1'b1));
        // ---- abort at RUN cycle 3 ----
        repeat (2) @(posedge clk);
        #1;
        ab[0] = 1'b1;
        @(posedge clk); #1;
        ab[0] = 1'b0;
        check("abort_run_fsm", 320'(dst[0]), 320'(ST_IDLE));
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (ov[0] === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_run_no_out_valid", 320'(seen), 320'(1'b0));
        // ---- abort coincident with out_ready in DONE ----
        st = rand_state();
        do_perm(0, st, 1'b0, 1'b0, 1'b0, res, lat, rc0, rcl);
        check("abort_done_state", res, model_perm(st, 6));
        ab[0] = 1'b1; ordy[0] = 1'b1;
        @(posedge clk); #1;
        ab[0] = 1'b0; ordy[0] = 1'b0;
        check("abort_done_fsm", 320'(dst[0]), 320'(ST_IDLE));
        check("abort_done_out_valid", 320'(ov[0]), 320'(1'b0));
        st = rand_state();
        do_perm(0, st, 1'b1, 1'b0, 1'b1, res, lat, rc0, rcl);
        check("abort_reload_state", res, model_perm(st, 12));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_perm_iter.md
Name: ascon_perm_iter

Overview:
- Iterative Ascon permutation engine over the 320-bit state: constant addition, bitsliced 5-bit S-box layer and linear diffusion.
- Runs pa (12 rounds) or pb (ROUNDS_B rounds), with UNROLL rounds per clock.
- Sits between the mode controller (absorb/squeeze logic) and the state register file.
- Valid/ready on both sides.

Parameters:
- UNROLL, 1, rounds per clock; legal values 1 or 2 (must divide 12 and ROUNDS_B).
- ROUNDS_B, 6, pb round count; legal values 6 or 8.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  load request
- in_ready  output  1  engine can accept a load
- in_state  input  320  state; x0=[63:0], x1=[127:64], x2=[191:128], x3=[255:192], x4=[319:256]
- in_mode  input  1  1 = pa (12 rounds), 0 = pb (ROUNDS_B rounds)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_state  output  320  permuted state, same word mapping
- busy  output  1  high in RUN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: FSM=IDLE, out_valid=0, out_state=0, round counter=0, busy=0. in_ready=1 while IDLE, including during reset.
- FSM states IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_state, set nr = in_mode ? 12 : ROUNDS_B, clear counter r=0, go to RUN.
  - RUN: each cycle apply UNROLL rounds, then r += UNROLL. When r+UNROLL == nr, go to DONE and assert out_valid. in_ready=0.
  - DONE: out_valid=1 and out_state held stable until out_ready. On the handshake go to IDLE. No same-cycle reload; in_ready stays 0 in DONE.
- Latency: load accepted at edge k; out_valid is high after edge k + nr/UNROLL.
  - UNROLL=1: pa 12 cycles, pb6 6 cycles.
  - UNROLL=2: pa 6 cycles, pb6 3 cycles.
- Round r (0-based, within the selected permutation):
  - Global index ir = 12 - nr + r, 4-bit.
  - Constant c = {56'h0, 4'hf - ir, ir}; x2 ^= c.
  - S-box:
    - x0^=x4; x4^=x3; x2^=x1.
    - t_i = ~x_i & x_(i+1 mod 5); x_i ^= t_(i+1 mod 5).
    - x1^=x0; x0^=x4; x3^=x2; x2=~x2.
  - Linear layer (right rotations):
    - x0 ^= ror19 ^ ror28
    - x1 ^= ror61 ^ ror39
    - x2 ^= ror1 ^ ror6
    - x3 ^= ror10 ^ ror17
    - x4 ^= ror7 ^ ror41
  - With UNROLL=2 the second round uses ir+1.
- Boundaries:
  - in_valid with in_mode changing while not in IDLE is ignored.
  - out_ready while not in DONE is ignored.
  - The counter never exceeds nr; 4-bit arithmetic, no wrap for legal parameters.
- Reset mid-RUN or mid-DONE: immediate return to IDLE, out_valid=0, and the result is discarded.
- Illegal parameter values: elaboration-time fatal error.

Optional Feature:
- Macro ASCON_PERM_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in RUN or DONE returns the FSM to IDLE at the next edge with out_valid=0; abort in IDLE has no effect. If abort and out_ready handshake coincide in DONE, abort wins and no transfer is counted.
- Undefined: no port; behaviour as above.

Decomposition:
- Package ascon_pkg:
  - STATE_W=320, WORD_W=64
  - PA_ROUNDS=12
  - rc(ir) function returning the 64-bit constant
  - state-word slice helpers
  - FSM state typedef
- Sub-module ascon_round: purely combinational single round (inputs: state, ir; output: state), instantiated UNROLL times in a chain.

Test Plan:
- Reset, then in_state=0, in_mode=1, UNROLL=1:
  - out_valid rises exactly 12 cycles after acceptance.
  - out_state matches the software Ascon-p[12] model.
  - Probed first-round constant is 0xf0.
- in_mode=0, ROUNDS_B=6: first constant 0x96, last 0x4b, 6-cycle latency, output matches the p[6] model. Repeat with ROUNDS_B=8: first constant 0xb4.
- UNROLL=2, 1000 random states in both modes:
  - Outputs equal the UNROLL=1 reference.
  - Latency is 6 (pa) and 3 (pb6) cycles.
- Hold out_ready=0 for 5 cycles in DONE:
  - out_valid and out_state stable; in_ready=0; in_valid pulses ignored.
  - Release: handshake, then IDLE next cycle.
- Assert rst asynchronously at cycle 4 of a pa run:
  - out_valid=0, busy=0, in_ready=1 immediately.
  - A new load afterwards produces a correct result.
- With ASCON_PERM_ABORT_EN: abort at RUN cycle 3 gives IDLE next edge and no out_valid; abort coincident with out_ready in DONE gives no transfer.
